// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus: push side, pop side, decoded head fields and occupancy.
// Handshake: a push transfers when in_valid && in_ready, a pop when out_valid && out_ready, both at the rising edge.
interface inst_queue_if #(
  parameter int PTR_W = 2
);
  logic              in_valid;
  logic [31:0]       in_inst;
  logic [31:0]       in_pc;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic [5:0]        out_op;
  logic [5:0]        out_funct;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [31:0]       out_imm;
  logic [PTR_W:0]    count;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_op, out_funct,
           out_rs, out_rt, out_rd, out_shamt, out_imm, count
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_op, out_funct,
           out_rs, out_rt, out_rd, out_shamt, out_imm, count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with zero-latency head and combinational decode.
// Storage is never cleared; only pointers and count are reset or flushed.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  inst_queue_if.slave   q
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]    inst_mem_q [DEPTH];
  logic [31:0]    pc_mem_q   [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [31:0]      head_inst;

  // in_ready depends on count only, so a pop cannot make room for a same-cycle push
  assign q.in_ready  = (count_q < FULL_CNT);
  assign q.out_valid = (count_q != '0);
  assign push = q.in_valid  && q.in_ready  && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (q.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      inst_mem_q[wp_q] <= q.in_inst;
      pc_mem_q[wp_q]   <= q.in_pc;
    end
  end

  // An empty queue presents a NOP at pc 0 so decode sees all-zero fields
  assign head_inst  = q.out_valid ? inst_mem_q[rp_q] : 32'h0000_0000;
  assign q.out_inst = head_inst;
  assign q.out_pc   = q.out_valid ? pc_mem_q[rp_q] : 32'h0000_0000;
  assign q.count    = count_q;

  assign q.out_op    = head_inst[31:26];
  assign q.out_rs    = head_inst[25:21];
  assign q.out_rt    = head_inst[20:16];
  assign q.out_rd    = head_inst[15:11];
  assign q.out_shamt = head_inst[10:6];
  assign q.out_funct = head_inst[5:0];
  assign q.out_imm   = {{16{head_inst[15]}}, head_inst[15:0]};
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table of per-cycle inputs and expected queue state, plus decode sequences.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_queue_if #(.PTR_W(PTR_W)) bus ();

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  typedef struct {
    logic           rst;
    logic           iv;
    logic [31:0]    pc;
    logic           fl;
    logic           ordy;
    logic           e_ir;
    logic           e_ov;
    logic [PTR_W:0] e_cnt;
    logic [31:0]    e_pc;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Distinct, sign-bit-set instruction word per pc so stale or reordered entries show up
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC3A5_8000 + pc * 3;
  endfunction

  function automatic void add(input logic rst, input logic iv, input logic [31:0] pc,
                              input logic fl, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [PTR_W:0] e_cnt,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.pc = pc; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.e_pc = e_pc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic fl, input logic ordy);
    @(negedge clk);
    reset        = rst;
    bus.in_valid = iv;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    bus.flush    = fl;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e_inst;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;

    // rst iv pc fl ordy | in_ready out_valid count out_pc
    add(1, 0, 32'h00, 0, 0, 1, 0, 0, 32'h00);
    add(0, 1, 32'h00, 0, 0, 1, 1, 1, 32'h00);
    add(0, 1, 32'h04, 0, 0, 1, 1, 2, 32'h00);
    add(0, 1, 32'h08, 0, 0, 1, 1, 3, 32'h00);
    add(0, 1, 32'h0C, 0, 0, 0, 1, 4, 32'h00);
    add(0, 1, 32'h10, 0, 0, 0, 1, 4, 32'h00);
    add(0, 1, 32'h10, 0, 1, 1, 1, 3, 32'h04);
    add(0, 0, 32'h00, 0, 1, 1, 1, 2, 32'h08);
    add(0, 0, 32'h00, 0, 1, 1, 1, 1, 32'h0C);
    add(0, 0, 32'h00, 0, 1, 1, 0, 0, 32'h00);
    add(0, 0, 32'h00, 0, 1, 1, 0, 0, 32'h00);
    add(0, 1, 32'h20, 0, 0, 1, 1, 1, 32'h20);
    add(0, 1, 32'h24, 0, 0, 1, 1, 2, 32'h20);
    for (int k = 0; k < 6; k++)
      add(0, 1, 32'h28 + 32'(4*k), 0, 1, 1, 1, 2, 32'h24 + 32'(4*k));
    add(0, 1, 32'h40, 0, 0, 1, 1, 3, 32'h38);
    add(0, 1, 32'h44, 1, 1, 1, 0, 0, 32'h00);
    add(0, 1, 32'h48, 0, 0, 1, 1, 1, 32'h48);
    add(0, 1, 32'h4C, 0, 0, 1, 1, 2, 32'h48);
    add(0, 1, 32'h50, 0, 0, 1, 1, 3, 32'h48);
    add(1, 1, 32'h54, 1, 1, 1, 0, 0, 32'h00);
    add(0, 1, 32'h40, 0, 0, 1, 1, 1, 32'h40);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].iv, inst_of(vecs[i].pc), vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      e_inst = vecs[i].e_ov ? inst_of(vecs[i].e_pc) : 32'h0;
      chk("in_ready",  i, 32'(bus.in_ready),  32'(vecs[i].e_ir));
      chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk("count",     i, 32'(bus.count),     32'(vecs[i].e_cnt));
      chk("out_pc",    i, bus.out_pc,         vecs[i].e_pc);
      chk("out_inst",  i, bus.out_inst,       e_inst);
      chk("out_op",    i, 32'(bus.out_op),    32'(e_inst[31:26]));
      chk("out_funct", i, 32'(bus.out_funct), 32'(e_inst[5:0]));
      chk("out_imm",   i, bus.out_imm,        {{16{e_inst[15]}}, e_inst[15:0]});
    end

    // addi $t0, $zero, 5
    apply(1, 0, 32'h0, 32'h0, 0, 0);
    apply(0, 1, 32'h2008_0005, 32'h0, 0, 0);
    chk("addi_valid", 100, 32'(bus.out_valid), 32'h1);
    chk("addi_op",    100, 32'(bus.out_op),    32'h08);
    chk("addi_rs",    100, 32'(bus.out_rs),    32'h00);
    chk("addi_rt",    100, 32'(bus.out_rt),    32'h08);
    chk("addi_rd",    100, 32'(bus.out_rd),    32'h00);
    chk("addi_funct", 100, 32'(bus.out_funct), 32'h05);
    chk("addi_imm",   100, bus.out_imm,        32'h0000_0005);
    chk("addi_count", 100, 32'(bus.count),     32'h1);

    // lw $t1, -4($zero): negative immediate sign-extends
    apply(1, 0, 32'h0, 32'h0, 0, 0);
    apply(0, 1, 32'h8C09_FFFC, 32'h100, 0, 0);
    chk("lw_imm",   101, bus.out_imm,         32'hFFFF_FFFC);
    chk("lw_op",    101, 32'(bus.out_op),     32'h23);
    chk("lw_rs",    101, 32'(bus.out_rs),     32'h00);
    chk("lw_rt",    101, 32'(bus.out_rt),     32'h09);
    chk("lw_rd",    101, 32'(bus.out_rd),     32'h1F);
    chk("lw_shamt", 101, 32'(bus.out_shamt),  32'h1F);
    chk("lw_funct", 101, 32'(bus.out_funct),  32'h3C);
    chk("lw_pc",    101, bus.out_pc,          32'h100);

    // pop the last word, then the empty queue must decode to all zeros
    apply(0, 0, 32'h0, 32'h0, 0, 1);
    chk("empty_inst", 102, bus.out_inst,        32'h0);
    chk("empty_rt",   102, 32'(bus.out_rt),     32'h0);
    chk("empty_imm",  102, bus.out_imm,         32'h0);

    apply(0, 0, 32'h0, 32'h0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
